digit_serial_addsub: RTL and testbench

Digit-serial adder/subtractor that processes `DIGIT_W` bits per beat, least-significant digit first, over words of up to `MAX_BEATS` beats. It generalises the bit-serial valid/last adder with several additions:
- a per-word add/subtract mode;
- registered, valid-qualified outputs;
- final carry/borrow and signed-overflow flags;
- protection against over-length words.

It sits in the sequential-arithmetic datapath, between serialising front ends and downstream accumulators.

---
 rtl/digit_serial_addsub.sv | 118 +++++++++++
 tb/tb_digit_serial_addsub.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT_W bits per beat, LSD first, words of up to MAX_BEATS beats.
// Registered outputs carry the result digit plus end-of-word carry, signed overflow and length-error flags.
module digit_serial_addsub #(
   parameter int DIGIT_W   = 4,
   parameter int MAX_BEATS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vld,
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               sub,
   input  logic               last,
   output logic               out_vld,
   output logic [DIGIT_W-1:0] sum,
   output logic               out_last,
   output logic               carry_out,
   output logic               overflow,
   output logic               err_len
);

   localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

   typedef enum logic {
      PH_FIRST = 1'b0,
      PH_MID   = 1'b1
   } phase_t;

   phase_t             phase_q, phase_d;
   logic               carry_q, carry_d;
   logic               mode_q, mode_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               out_vld_q, out_vld_d;
   logic [DIGIT_W-1:0] sum_q, sum_d;
   logic               out_last_q, out_last_d;
   logic               carry_out_q, carry_out_d;
   logic               overflow_q, overflow_d;
   logic               err_len_q, err_len_d;

   logic               m;
   logic               cin;
   logic [DIGIT_W-1:0] b_x;
   logic [DIGIT_W:0]   full;
   logic               cmsb;
   logic               at_limit;
   logic               end_w;

   always_comb begin
      m        = (phase_q == PH_FIRST) ? sub : mode_q;
      cin      = (phase_q == PH_FIRST) ? sub : carry_q;
      b_x      = b ^ {DIGIT_W{m}};
      full     = {1'b0, a} + {1'b0, b_x} + {{DIGIT_W{1'b0}}, cin};
      // Carry into the top bit recovered from the sum bit: s = a ^ b ^ cin at that position.
      cmsb     = full[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_x[DIGIT_W-1];
      at_limit = (cnt_q == CNT_LAST);
      end_w    = last | at_limit;

      phase_d = phase_q;
      carry_d = carry_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      if (vld) begin
         if (end_w) begin
            carry_d = 1'b0;
            cnt_d   = '0;
            phase_d = PH_FIRST;
         end else begin
            carry_d = full[DIGIT_W];
            mode_d  = m;
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = PH_MID;
         end
      end

      out_vld_d   = vld;
      sum_d       = vld ? full[DIGIT_W-1:0] : sum_q;
      out_last_d  = vld & end_w;
      carry_out_d = vld & end_w & full[DIGIT_W];
      overflow_d  = vld & end_w & (full[DIGIT_W] ^ cmsb);
      err_len_d   = vld & at_limit & ~last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q     <= PH_FIRST;
         carry_q     <= 1'b0;
         mode_q      <= 1'b0;
         cnt_q       <= '0;
         out_vld_q   <= 1'b0;
         sum_q       <= '0;
         out_last_q  <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         err_len_q   <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         carry_q     <= carry_d;
         mode_q      <= mode_d;
         cnt_q       <= cnt_d;
         out_vld_q   <= out_vld_d;
         sum_q       <= sum_d;
         out_last_q  <= out_last_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         err_len_q   <= err_len_d;
      end
   end

   assign out_vld   = out_vld_q;
   assign sum       = sum_q;
   assign out_last  = out_last_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;
   assign err_len   = err_len_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: directed word scenarios plus randomized beats against a whole-word arithmetic model.
module tb_digit_serial_addsub;

   localparam int W  = 4;
   localparam int MB = 4;

   typedef logic [8:0] obs_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         vld = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         last = 1'b0;
   logic         out_vld;
   logic [W-1:0] sum;
   logic         out_last;
   logic         carry_out;
   logic         overflow;
   logic         err_len;

   int checks = 0;
   int failures = 0;

   digit_serial_addsub #(.DIGIT_W(W), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst(rst), .vld(vld), .a(a), .b(b), .sub(sub), .last(last),
      .out_vld(out_vld), .sum(sum), .out_last(out_last), .carry_out(carry_out),
      .overflow(overflow), .err_len(err_len)
   );

   always #5 clk = ~clk;

   // Output bundle: {out_vld, sum, out_last, carry_out, overflow, err_len}
   function automatic obs_t obs();
      return {out_vld, sum, out_last, carry_out, overflow, err_len};
   endfunction

   task automatic drive(input logic r, input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic s, input logic l);
      rst = r; vld = v; a = aa; b = bb; sub = s; last = l;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 4'h5, 4'h7, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      checks++;
      if (obs() !== 9'h000) begin
         failures++; $display("FAIL reset_outputs got=%h exp=%h", obs(), 9'h000);
      end
   endtask

   task automatic test_add();
      drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 4'hA, 4'hF, 1'b0, 1'b0);
      checks++;
      if (obs() !== {1'b1, 4'h9, 4'b0000}) begin
         failures++; $display("FAIL add_beat0 got=%h exp=%h", obs(), {1'b1, 4'h9, 4'b0000});
      end
      drive(1'b0, 1'b1, 4'h3, 4'h0, 1'b0, 1'b1);
      checks++;
      if (obs() !== {1'b1, 4'h4, 4'b1000}) begin
         failures++; $display("FAIL add_beat1 got=%h exp=%h", obs(), {1'b1, 4'h4, 4'b1000});
      end
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      checks++;
      if (obs() !== {1'b0, 4'h4, 4'b0000}) begin
         failures++; $display("FAIL add_idle got=%h exp=%h", obs(), {1'b0, 4'h4, 4'b0000});
      end
   endtask

   task automatic test_sub();
      drive(1'b0, 1'b1, 4'h0, 4'h1, 1'b1, 1'b0);
      checks++;
      if (obs() !== {1'b1, 4'hF, 4'b0000}) begin
         failures++; $display("FAIL sub_beat0 got=%h exp=%h", obs(), {1'b1, 4'hF, 4'b0000});
      end
      drive(1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 1'b1);
      checks++;
      if (obs() !== {1'b1, 4'h0, 4'b1100}) begin
         failures++; $display("FAIL sub_beat1 got=%h exp=%h", obs(), {1'b1, 4'h0, 4'b1100});
      end
   endtask

   task automatic test_overflow();
      drive(1'b0, 1'b1, 4'hF, 4'h1, 1'b0, 1'b0);
      checks++;
      if (obs() !== {1'b1, 4'h0, 4'b0000}) begin
         failures++; $display("FAIL ovf_beat0 got=%h exp=%h", obs(), {1'b1, 4'h0, 4'b0000});
      end
      drive(1'b0, 1'b1, 4'h7, 4'h0, 1'b0, 1'b1);
      checks++;
      if (obs() !== {1'b1, 4'h8, 4'b1010}) begin
         failures++; $display("FAIL ovf_beat1 got=%h exp=%h", obs(), {1'b1, 4'h8, 4'b1010});
      end
   endtask

   task automatic test_bubbles();
      drive(1'b0, 1'b1, 4'hA, 4'hF, 1'b0, 1'b0);
      checks++;
      if (obs() !== {1'b1, 4'h9, 4'b0000}) begin
         failures++; $display("FAIL bub_beat0 got=%h exp=%h", obs(), {1'b1, 4'h9, 4'b0000});
      end
      drive(1'b0, 1'b0, 4'hC, 4'hC, 1'b1, 1'b1);
      checks++;
      if (obs() !== {1'b0, 4'h9, 4'b0000}) begin
         failures++; $display("FAIL bub_gap got=%h exp=%h", obs(), {1'b0, 4'h9, 4'b0000});
      end
      drive(1'b0, 1'b1, 4'h3, 4'h0, 1'b1, 1'b1);
      checks++;
      if (obs() !== {1'b1, 4'h4, 4'b1000}) begin
         failures++; $display("FAIL bub_beat1 got=%h exp=%h", obs(), {1'b1, 4'h4, 4'b1000});
      end
   endtask

   task automatic test_overlength();
      obs_t exp;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0);
         exp = {1'b1, 4'h2, (i == 3), 1'b0, 1'b0, (i == 3)};
         checks++;
         if (obs() !== exp) begin
            failures++; $display("FAIL overlen_beat%0d got=%h exp=%h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_reset_midword();
      drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 4'hF, 4'h1, 1'b0, 1'b0);
      checks++;
      if (obs() !== {1'b1, 4'h0, 4'b0000}) begin
         failures++; $display("FAIL rstmid_beat0 got=%h exp=%h", obs(), {1'b1, 4'h0, 4'b0000});
      end
      drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
      checks++;
      if (obs() !== 9'h000) begin
         failures++; $display("FAIL rstmid_rst got=%h exp=%h", obs(), 9'h000);
      end
      drive(1'b0, 1'b1, 4'h1, 4'h1, 1'b0, 1'b1);
      checks++;
      if (obs() !== {1'b1, 4'h2, 4'b1000}) begin
         failures++; $display("FAIL rstmid_after got=%h exp=%h", obs(), {1'b1, 4'h2, 4'b1000});
      end
   endtask

   // Model: accumulate whole operands and compute the word result with plain integer arithmetic.
   task automatic test_random();
      logic         in_word = 1'b0;
      logic         mode = 1'b0;
      int           k = 0;
      int           n;
      longint       opa = 0, opb = 0, r, mask, half, sa, sb, sr;
      logic [W-1:0] es = '0;
      logic         rv, vv, sv, lv, e_end, cy, ov, er;
      logic [W-1:0] av, bv;
      obs_t         exp;
      drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < 600; i++) begin
         rv = ($urandom_range(0, 49) == 0);
         vv = ($urandom_range(0, 3) != 0);
         sv = ($urandom_range(0, 1) == 1);
         lv = ($urandom_range(0, 2) == 0);
         av = 4'($urandom);
         bv = 4'($urandom);
         if (rv) begin
            in_word = 1'b0;
            es = '0;
            exp = '0;
         end else if (vv) begin
            if (!in_word) begin
               mode = sv; k = 0; opa = 0; opb = 0;
            end
            opa = opa | (longint'(av) << (k * W));
            opb = opb | (longint'(bv) << (k * W));
            n = k + 1;
            mask = (longint'(1) << (n * W)) - 1;
            r = mode ? (opa - opb) : (opa + opb);
            es = 4'((r & mask) >> (k * W));
            e_end = lv || (k == MB - 1);
            cy = 1'b0; ov = 1'b0; er = 1'b0;
            if (e_end) begin
               half = longint'(1) << (n * W - 1);
               sa = (opa >= half) ? opa - 2 * half : opa;
               sb = (opb >= half) ? opb - 2 * half : opb;
               sr = mode ? (sa - sb) : (sa + sb);
               ov = (sr >= half) || (sr < -half);
               cy = mode ? (opa >= opb) : (((opa + opb) >> (n * W)) != 0);
               er = (k == MB - 1) && !lv;
               in_word = 1'b0;
            end else begin
               k++;
               in_word = 1'b1;
            end
            exp = {1'b1, es, e_end, cy, ov, er};
         end else begin
            exp = {1'b0, es, 4'b0000};
         end
         drive(rv, vv, av, bv, sv, lv);
         checks++;
         if (obs() !== exp) begin
            failures++; $display("FAIL random_cyc%0d got=%h exp=%h", i, obs(), exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_bubbles();
      test_overlength();
      test_reset_midword();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
